nibble_frame_serializer: RTL and testbench



---
 rtl/seqdet_pkg.sv | 16 +
 rtl/nibble_frame_serializer_if.sv | 9 +
 rtl/sync_fifo_nib.sv | 43 ++++
 rtl/nibble_frame_serializer.sv | 97 +++++++++
 tb/tb_nibble_frame_serializer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/seqdet_pkg.sv
// Definitions shared by the nibble serializer and the downstream sequence detector.
package seqdet_pkg;

    localparam int FRAME_LEN = 4;

    typedef enum logic [$clog2(FRAME_LEN)-1:0] {PH0, PH1, PH2, PH3} phase_t;

    localparam logic [3:0] PAT_0111 = 4'b0111;
    localparam logic [3:0] PAT_1001 = 4'b1001;
    localparam logic [3:0] PAT_1110 = 4'b1110;

    function automatic logic is_detect_pattern(input logic [3:0] n);
        return (n == PAT_0111) || (n == PAT_1001) || (n == PAT_1110);
    endfunction

endpackage

// File: rtl/nibble_frame_serializer_if.sv
// Valid/ready nibble handshake between a test-nibble producer and the serializer.
interface nibble_frame_serializer_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sync_fifo_nib.sv
// DEPTH x 4 synchronous FIFO; head is read combinationally, level tracks occupancy.
module sync_fifo_nib #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [3:0]             din,
    input  logic                   pop,
    output logic [3:0]             head,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    // Callers guarantee push only when not full and pop only when not empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/nibble_frame_serializer.sv
// Buffers test nibbles and emits them MSB-first on a fixed 4-cycle frame grid,
// padding with a non-matching FILL frame whenever the FIFO is empty.
//
//   ph  | meaning
//   PH0 | frame bit 3 on ser_out, frame_start high
//   PH1 | frame bit 2
//   PH2 | frame bit 1
//   PH3 | frame bit 0; next frame (FIFO head or FILL) loads on leaving
module nibble_frame_serializer
    import seqdet_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [3:0] FILL  = 4'b0000,
    parameter int         CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nibble_frame_serializer_if.slave up,
    output logic                   ser_out,
    output logic                   ser_valid,
    output logic                   frame_start,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       frame_cnt
);
    localparam int LW = $clog2(DEPTH) + 1;

    if (is_detect_pattern(FILL)) begin : g_bad_fill
        $error("FILL pattern would trigger the detector");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end

    phase_t           ph;
    phase_t           ph_nxt;
    logic [3:0]       sr;
    logic [3:0]       sr_nxt;
    logic             ser_valid_nxt;
    logic             frame_start_nxt;
    logic [CNT_W-1:0] frame_cnt_nxt;
    logic             push;
    logic             pop;
    logic [3:0]       head;

    // Ready follows the registered level only, so a full FIFO refuses even when popping.
    assign up.in_ready = (level < LW'(DEPTH));
    assign push        = up.in_valid && up.in_ready;
    assign ser_out     = sr[3];

    sync_fifo_nib #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (up.in_data),
        .pop   (pop),
        .head  (head),
        .level (level)
    );

    always_comb begin
        ph_nxt          = phase_t'(ph + 1'b1);
        sr_nxt          = {sr[2:0], 1'b0};
        ser_valid_nxt   = ser_valid;
        frame_start_nxt = (ph == PH3);
        frame_cnt_nxt   = frame_cnt;
        pop             = 1'b0;
        if (ph == PH3) begin
            if (level != '0) begin
                pop           = 1'b1;
                sr_nxt        = head;
                ser_valid_nxt = 1'b1;
                frame_cnt_nxt = frame_cnt + CNT_W'(1);
            end else begin
                sr_nxt        = FILL;
                ser_valid_nxt = 1'b0;
            end
        end
    end

    // Reset starts a FILL frame immediately so the detector window stays aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph          <= PH0;
            sr          <= FILL;
            ser_valid   <= 1'b0;
            frame_start <= 1'b1;
            frame_cnt   <= '0;
        end else begin
            ph          <= ph_nxt;
            sr          <= sr_nxt;
            ser_valid   <= ser_valid_nxt;
            frame_start <= frame_start_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_nibble_frame_serializer.sv
// Randomized scoreboard bench: accepted nibbles are scheduled into frame slots by
// arithmetic on the cycle number; a monitor checks every serial cycle against them.
module tb_nibble_frame_serializer;
    import seqdet_pkg::*;

    localparam int         DEPTH  = 4;
    localparam logic [3:0] FILL   = 4'b0000;
    localparam int         CNT_W  = 4;

    typedef struct {
        logic [3:0] nib;
        int         acc;
        int         start;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   ser_out;
    logic                   ser_valid;
    logic                   frame_start;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       frame_cnt;

    nibble_frame_serializer_if bus();

    nibble_frame_serializer #(.DEPTH(DEPTH), .FILL(FILL), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .up          (bus),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .level       (level),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    exp_t exp_q[$];
    int   pend[$];
    int   last_start = 0;

    // Cycle k after reset release is the k-th clock period following the last reset edge.
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        exp_q.delete();
        pend.delete();
        last_start = 0;
        mon_en = 1'b1;
        repeat (n - 1) @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle; a nibble accepted in cycle k goes out at the first frame
    // boundary strictly after k+1, and never before the previously scheduled frame ends.
    task automatic cycle_in(input logic v, input logic [3:0] d, output logic accepted);
        int k;
        int s;
        k = cyc;
        while (pend.size() > 0 && pend[0] <= k) void'(pend.pop_front());
        bus.in_valid = v;
        bus.in_data  = d;
        accepted = v && (pend.size() < DEPTH);
        if (accepted) begin
            s = ((k + 1) / FRAME_LEN) * FRAME_LEN + FRAME_LEN;
            if (s < last_start + FRAME_LEN) s = last_start + FRAME_LEN;
            last_start = s;
            pend.push_back(s);
            exp_q.push_back('{nib: d, acc: k, start: s});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic a;
        repeat (n) cycle_in(1'b0, 4'($urandom_range(0, 15)), a);
    endtask

    function automatic logic [3:0] rand_nib();
        logic [3:0] pats [3];
        pats[0] = PAT_0111;
        pats[1] = PAT_1001;
        pats[2] = PAT_1110;
        if ($urandom_range(0, 1) == 1) return pats[$urandom_range(0, 2)];
        return 4'($urandom_range(0, 15));
    endfunction

    // Monitor: sampled 1 time unit after the falling edge, after the driver has acted.
    logic [3:0]       cur_nib = FILL;
    logic             cur_real = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               m_k;
    int               m_ph;
    int               m_lvl;
    exp_t             m_e;

    always begin
        @(negedge clk);
        #1;
        if (mon_en) begin
            m_k  = cyc;
            m_ph = m_k % FRAME_LEN;
            if (m_ph == 0) begin
                if (m_k == 0) exp_cnt = '0;
                cur_nib  = FILL;
                cur_real = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].start <= m_k) begin
                    m_e = exp_q.pop_front();
                    chk("frame_slot", m_k, m_e.start);
                    cur_nib  = m_e.nib;
                    cur_real = 1'b1;
                    exp_cnt  = exp_cnt + 1'b1;
                end
            end
            m_lvl = 0;
            foreach (exp_q[i]) if (exp_q[i].acc < m_k) m_lvl++;
            chk("ser_out", int'(ser_out), int'(cur_nib[3 - m_ph]));
            chk("ser_valid", int'(ser_valid), int'(cur_real));
            chk("frame_start", int'(frame_start), int'(m_ph == 0));
            chk("frame_cnt", int'(frame_cnt), int'(exp_cnt));
            chk("level", int'(level), m_lvl);
            chk("in_ready", int'(bus.in_ready), int'(m_lvl < DEPTH));
        end
    end

    initial begin
        logic a;
        int   idx;
        int   guard;
        logic [3:0] b2b [5];
        b2b[0] = 4'b1110; b2b[1] = 4'b1001; b2b[2] = 4'b0111; b2b[3] = 4'b0000; b2b[4] = 4'b1110;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'h0;

        // Reset values and idle fill frames.
        do_reset(3);
        chk("rst_level", int'(level), 0);
        chk("rst_ser_out", int'(ser_out), int'(FILL[3]));
        idle(12);

        // Single push at phase 1, then a push at phase 3 that must wait a frame.
        do_reset(2);
        idle(1);
        cycle_in(1'b1, PAT_0111, a);
        idle(10);
        do_reset(2);
        idle(3);
        cycle_in(1'b1, PAT_1001, a);
        idle(12);

        // Back-to-back pushes with valid held high until accepted.
        do_reset(2);
        idx = 0;
        guard = 0;
        while (idx < 5 && guard < 100) begin
            cycle_in(1'b1, b2b[idx], a);
            if (a) idx++;
            guard++;
        end
        chk("b2b_all_accepted", idx, 5);
        idle(28);
        chk("b2b_frame_cnt", int'(frame_cnt), 5);

        // Reset in phase 2 of a real frame with 3 nibbles queued.
        do_reset(2);
        for (int i = 0; i < 4; i++) cycle_in(1'b1, rand_nib(), a);
        idle(2);
        chk("pre_rst_level", int'(level), 3);
        do_reset(1);
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_valid", int'(ser_valid), 0);
        idle(16);

        // Counter wrap: 17 real frames on a 4-bit counter.
        do_reset(2);
        idx = 0;
        guard = 0;
        while (idx < 17 && guard < 200) begin
            cycle_in(1'b1, rand_nib(), a);
            if (a) idx++;
            guard++;
        end
        idle(24);
        chk("wrap_frame_cnt", int'(frame_cnt), 1);

        // Random traffic with occasional resets at arbitrary phases.
        do_reset(2);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 3)));
            else cycle_in(($urandom_range(0, 99) < 45), rand_nib(), a);
        end
        idle(30);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
